// File: rtl/fir_pkg.sv
// Shared definitions for the time-shared FIR MAC sequencer: state encoding,
// channel indices and default geometry.
package fir_pkg;

  localparam int TAPS_DEF   = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int CH_H = 0;
  localparam int CH_L = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR_H = 3'd1,
    MAC_H = 3'd2,
    OUT_H = 3'd3,
    CLR_L = 3'd4,
    MAC_L = 3'd5,
    OUT_L = 3'd6
  } state_t;

  // H always runs before L; an all-zero enable never starts a sequence.
  function automatic state_t first_clr(input logic [1:0] en);
    state_t s;
    if (en[CH_H]) begin
      s = CLR_H;
    end else if (en[CH_L]) begin
      s = CLR_L;
    end else begin
      s = IDLE;
    end
    return s;
  endfunction

endpackage

// File: rtl/fir_mac_sched_if.sv
// Control bus between the MAC sequencer and the shared FIR datapath.
interface fir_mac_sched_if #(
  parameter int ADDR_W = fir_pkg::ADDR_W_DEF
);
  import fir_pkg::*;

  logic              sample;
  logic [1:0]        ch_en;
  logic [ADDR_W-1:0] tap;
  logic [ADDR_W-1:0] coef_addr;
  logic              ch_sel;
  logic              clr;
  logic              acc_en;
  logic              oe_h;
  logic              oe_l;
  logic              busy;
  logic              overrun;

  modport master (
    input  sample, ch_en,
    output tap, coef_addr, ch_sel, clr, acc_en, oe_h, oe_l, busy, overrun
  );

  modport slave (
    output sample, ch_en,
    input  tap, coef_addr, ch_sel, clr, acc_en, oe_h, oe_l, busy, overrun
  );

endinterface

// File: rtl/fir_tap_counter.sv
// Tap index up-counter with async reset, sync clear, enable and
// terminal-count flag (high when the count sits at its last value).
module fir_tap_counter
  import fir_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  // Count register; clear wins over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {ADDR_W{1'b0}};
    end else if (clr) begin
      count <= {ADDR_W{1'b0}};
    end else if (en) begin
      count <= count + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign tc = (count == {ADDR_W{1'b1}});

endmodule

// File: rtl/fir_mac_sched.sv
// Sequencer sharing one FIR MAC datapath between the H and L channels:
// one clear/MAC/output sweep per enabled channel on each accepted sample.
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  fir_mac_sched_if.master  bus
);

  state_t            state_r;
  state_t            state_next_s;
  logic [1:0]        en_r;
  logic [1:0]        en_next_s;
  logic              seq_end_s;
  logic              overrun_next_s;
  logic              in_mac_s;
  logic              tc_s;
  logic [ADDR_W-1:0] tap_s;

  assign in_mac_s = (state_r == MAC_H) || (state_r == MAC_L);

  // Held at zero outside MAC so every sweep starts from tap 0.
  fir_tap_counter #(.ADDR_W(ADDR_W)) u_tap (
    .clk   (clk),
    .reset (reset),
    .clr   (!in_mac_s),
    .en    (in_mac_s),
    .count (tap_s),
    .tc    (tc_s)
  );

  assign bus.tap       = tap_s;
  assign bus.coef_addr = ADDR_W'(TAPS) - tap_s;

  // Next-state, enable latch and overrun decode.
  always_comb begin
    state_next_s   = state_r;
    en_next_s      = en_r;
    seq_end_s      = (state_r == OUT_L) || ((state_r == OUT_H) && !en_r[CH_L]);
    overrun_next_s = 1'b0;

    case (state_r)
      IDLE:    state_next_s = IDLE;
      CLR_H:   state_next_s = en_r[CH_H] ? MAC_H : IDLE;
      MAC_H:   state_next_s = tc_s ? OUT_H : MAC_H;
      OUT_H:   state_next_s = en_r[CH_L] ? CLR_L : IDLE;
      CLR_L:   state_next_s = en_r[CH_L] ? MAC_L : IDLE;
      MAC_L:   state_next_s = tc_s ? OUT_L : MAC_L;
      OUT_L:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase

    // The last OUT cycle accepts a new strobe so sweeps can run back-to-back.
    if ((state_r == IDLE || seq_end_s) && bus.sample && (bus.ch_en != 2'b00)) begin
      en_next_s    = bus.ch_en;
      state_next_s = first_clr(bus.ch_en);
    end else begin
      en_next_s = en_r;
    end

    if (bus.sample && (state_r != IDLE) && !seq_end_s) begin
      overrun_next_s = 1'b1;
    end else begin
      overrun_next_s = 1'b0;
    end
  end

  // State, enable latch and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      en_r        <= 2'b00;
      bus.clr     <= 1'b0;
      bus.acc_en  <= 1'b0;
      bus.ch_sel  <= 1'b0;
      bus.oe_h    <= 1'b0;
      bus.oe_l    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      en_r        <= en_next_s;
      bus.clr     <= (state_next_s == CLR_H) || (state_next_s == CLR_L);
      bus.acc_en  <= (state_next_s == MAC_H) || (state_next_s == MAC_L);
      bus.ch_sel  <= (state_next_s == CLR_L) || (state_next_s == MAC_L) ||
                     (state_next_s == OUT_L);
      bus.oe_h    <= (state_next_s == OUT_H);
      bus.oe_l    <= (state_next_s == OUT_L);
      bus.busy    <= (state_next_s != IDLE);
      bus.overrun <= overrun_next_s;
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Scoreboard bench for fir_mac_sched: stimulus queues expected pulse events,
// a negedge monitor pops and compares them as the DUT produces pulses.
module tb_fir_mac_sched;

  localparam int EV_CLR = 0;
  localparam int EV_OEH = 1;
  localparam int EV_OEL = 2;
  localparam int EV_OVR = 3;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0;
  ev_t  evq[$];

  fir_mac_sched_if #(.ADDR_W(5)) bus ();

  fir_mac_sched #(.TAPS(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Keep the queue ordered by (cycle, kind) so out-of-order pushes still line up.
  task automatic push_ev(input int c, input int k);
    int  i;
    ev_t e;
    i = 0;
    while (i < evq.size() && (evq[i].cyc < c || (evq[i].cyc == c && evq[i].kind <= k))) i++;
    e.cyc  = c;
    e.kind = k;
    evq.insert(i, e);
  endtask

  task automatic expect_sweep(input int ts, input logic [1:0] en);
    int base;
    base = 0;
    if (en[0]) begin
      push_ev(ts + 1, EV_CLR);
      push_ev(ts + 34, EV_OEH);
      base = 34;
    end
    if (en[1]) begin
      push_ev(ts + base + 1, EV_CLR);
      push_ev(ts + base + 34, EV_OEL);
    end
  endtask

  task automatic issue(input logic [1:0] en);
    bus.sample = 1'b1;
    bus.ch_en  = en;
    @(negedge clk);
    bus.sample = 1'b0;
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [16:0] outs();
    return {bus.tap, bus.coef_addr, bus.ch_sel, bus.clr, bus.acc_en,
            bus.oe_h, bus.oe_l, bus.busy, bus.overrun};
  endfunction

  // Hand timeline of a dual-channel sweep, k cycles after the strobe.
  function automatic logic [16:0] exp_vec(input int k);
    logic [4:0] t;
    logic [4:0] ca;
    logic b, c, a, s, oh, ol;
    b  = (k >= 1 && k <= 68);
    c  = (k == 1 || k == 35);
    a  = (k >= 2 && k <= 33) || (k >= 36 && k <= 67);
    s  = (k >= 35 && k <= 68);
    oh = (k == 34);
    ol = (k == 68);
    if (k >= 2 && k <= 33) t = 5'(k - 2);
    else if (k >= 36 && k <= 67) t = 5'(k - 36);
    else t = 5'd0;
    ca = 5'((32 - int'(t)) % 32);
    return {t, ca, s, c, a, oh, ol, b, 1'b0};
  endfunction

  task automatic mon_pop(input int k);
    ev_t e;
    if (evq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event cyc=%0d got kind=%0d exp none", cyc, k);
    end else begin
      e = evq.pop_front();
      chk("event(kind<<24|cyc)", (k << 24) | cyc, (e.kind << 24) | e.cyc);
    end
  endtask

  // Monitor: every pulse on clr/oe_h/oe_l/overrun must match the queue head.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("exclusive", {30'd0, bus.clr & bus.acc_en, bus.oe_h & bus.oe_l}, 32'd0);
      if (bus.clr)     mon_pop(EV_CLR);
      if (bus.oe_h)    mon_pop(EV_OEH);
      if (bus.oe_l)    mon_pop(EV_OEL);
      if (bus.overrun) mon_pop(EV_OVR);
    end
  end

  initial begin
    reset      = 1'b1;
    bus.sample = 1'b0;
    bus.ch_en  = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full dual sweep, cycle by cycle; ch_en change mid-sweep must not matter.
    t0 = cyc;
    expect_sweep(t0, 2'b11);
    issue(2'b11);
    for (int k = 1; k <= 69; k++) begin
      at_cyc(t0 + k);
      chk("sweep_vec", 32'(outs()), 32'(exp_vec(k)));
      if (k == 10) bus.ch_en = 2'b01;
    end

    // L only.
    at_cyc(cyc + 2);
    t0 = cyc;
    expect_sweep(t0, 2'b10);
    issue(2'b10);
    at_cyc(t0 + 1);
    chk("l_only_chsel", 32'(bus.ch_sel), 32'd1);
    at_cyc(t0 + 35);
    chk("l_only_done", 32'(bus.busy), 32'd0);

    // H only.
    at_cyc(cyc + 2);
    t0 = cyc;
    expect_sweep(t0, 2'b01);
    issue(2'b01);
    at_cyc(t0 + 34);
    chk("h_only_busy", 32'(bus.busy), 32'd1);
    at_cyc(t0 + 35);
    chk("h_only_done", 32'(bus.busy), 32'd0);

    // Overrun mid MAC_H.
    at_cyc(cyc + 2);
    t0 = cyc;
    expect_sweep(t0, 2'b11);
    issue(2'b11);
    at_cyc(t0 + 20);
    push_ev(t0 + 21, EV_OVR);
    issue(2'b11);
    at_cyc(t0 + 71);
    chk("ovr_no_second", 32'(bus.busy), 32'd0);

    // Back-to-back acceptance at the final OUT cycle.
    at_cyc(cyc + 2);
    t0 = cyc;
    expect_sweep(t0, 2'b11);
    issue(2'b11);
    at_cyc(t0 + 68);
    expect_sweep(t0 + 68, 2'b01);
    issue(2'b01);
    at_cyc(t0 + 103);
    chk("b2b_done", 32'(bus.busy), 32'd0);

    // One cycle early: dropped with overrun.
    at_cyc(cyc + 2);
    t0 = cyc;
    expect_sweep(t0, 2'b11);
    issue(2'b11);
    at_cyc(t0 + 67);
    push_ev(t0 + 68, EV_OVR);
    issue(2'b11);
    at_cyc(t0 + 69);
    chk("early_idle", 32'(bus.busy), 32'd0);

    // Reset mid MAC_L, then a clean restart.
    at_cyc(cyc + 2);
    t0 = cyc;
    push_ev(t0 + 1, EV_CLR);
    push_ev(t0 + 34, EV_OEH);
    push_ev(t0 + 35, EV_CLR);
    issue(2'b11);
    at_cyc(t0 + 40);
    reset = 1'b1;
    #1;
    chk("reset_mid_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    chk("reset_hold_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    t0 = cyc;
    expect_sweep(t0, 2'b01);
    issue(2'b01);
    at_cyc(t0 + 35);
    chk("restart_done", 32'(bus.busy), 32'd0);

    // All-disabled strobe is ignored.
    at_cyc(cyc + 2);
    t0 = cyc;
    issue(2'b00);
    at_cyc(t0 + 3);
    chk("en00_idle", 32'(outs()), 32'd0);

    at_cyc(cyc + 5);
    chk("queue_empty", 32'(evq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
